// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid-register slice: default words and
// the occupancy-state encoding.
package pipe_pkg;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] ZERO_WORD        = 32'h0000_0000;

  // Bit 0 is MAIN.valid and bit 1 is SKID.valid, so the valid flags are the
  // state flops themselves and SKID-without-MAIN has no encoding.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b01,
    OCC_TWO   = 2'b11
  } occ_e;

endpackage

// File: rtl/pipe_skid_if.sv
// Upstream/downstream handshake bundle for pipe_skid_reg. The slave modport is
// the stage's view; the master modport is the surrounding pipeline's view.
interface pipe_skid_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_instr;
  logic [PC_W-1:0]   in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [PC_W-1:0]   out_pc;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc
  );

endinterface

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter used for the optional stage performance counters.
module pipe_perf_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-slot pipeline skid register with stall/flush; stall_cnt and flush_cnt
// ports exist only when PIPE_SKID_PERF_EN is defined.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                PC_W     = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEFAULT),
  parameter int                CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  pipe_skid_if.slave       bus
`ifdef PIPE_SKID_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  occ_e              state_q, state_d;
  logic [DATA_W-1:0] main_instr_q, main_instr_d;
  logic [PC_W-1:0]   main_pc_q, main_pc_d;
  logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
  logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
  logic              main_valid, skid_valid;
  logic              push, pop;

  assign main_valid = state_q[0];
  assign skid_valid = state_q[1];

  // Gated by rst so the stage refuses entries while held in reset.
  assign bus.in_ready = rst && !skid_valid && !stall;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = main_valid && bus.out_ready && !stall;

  assign bus.out_valid = main_valid;
  assign bus.out_instr = main_instr_q;
  assign bus.out_pc    = main_pc_q;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a variable unassigned and infer a latch.
    state_d      = state_q;
    main_instr_d = main_instr_q;
    main_pc_d    = main_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;

    if (flush) begin
      state_d      = OCC_EMPTY;
      main_instr_d = NOP_WORD;
    end else if (!stall) begin
      case (state_q)
        OCC_EMPTY: begin
          if (push) begin
            state_d      = OCC_ONE;
            main_instr_d = bus.in_instr;
            main_pc_d    = bus.in_pc;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            main_instr_d = bus.in_instr;
            main_pc_d    = bus.in_pc;
          end else if (push) begin
            state_d      = OCC_TWO;
            skid_instr_d = bus.in_instr;
            skid_pc_d    = bus.in_pc;
          end else if (pop) begin
            // Keep out_instr at NOP whenever MAIN is empty.
            state_d      = OCC_EMPTY;
            main_instr_d = NOP_WORD;
          end
        end
        OCC_TWO: begin
          if (pop) begin
            state_d      = OCC_ONE;
            main_instr_d = skid_instr_q;
            main_pc_d    = skid_pc_q;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= OCC_EMPTY;
      main_instr_q <= NOP_WORD;
      main_pc_q    <= PC_W'(ZERO_WORD);
      skid_instr_q <= NOP_WORD;
      skid_pc_q    <= PC_W'(ZERO_WORD);
    end else begin
      state_q      <= state_d;
      main_instr_q <= main_instr_d;
      main_pc_q    <= main_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

`ifdef PIPE_SKID_PERF_EN
  pipe_perf_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall && !flush),
    .cnt (stall_cnt)
  );

  pipe_perf_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush && (main_valid || skid_valid)),
    .cnt (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and model-checked random bench for pipe_skid_reg; build with and
// without PIPE_SKID_PERF_EN.
module tb_pipe_skid_reg;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic stall = 1'b0;
  logic flush = 1'b0;

  pipe_skid_if #(.DATA_W(32), .PC_W(32)) bus ();

`ifdef PIPE_SKID_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  pipe_skid_reg #(
    .DATA_W   (32),
    .PC_W     (32),
    .NOP_WORD (NOP),
    .CNT_W    (16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .stall (stall),
    .flush (flush),
    .bus   (bus.slave)
`ifdef PIPE_SKID_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic ordy);
    bus.in_valid  = v;
    bus.in_instr  = instr;
    bus.in_pc     = pc;
    bus.out_ready = ordy;
  endtask

  logic [31:0] got_q[$];
  logic [63:0] model_q[$];
  int          idx;
  int          m_stall_cnt, m_flush_cnt;
  logic        m_ready;

  initial begin
    drive(1'b0, 32'h0, 32'h0, 1'b0);

    // Reset state
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_instr", bus.out_instr, NOP);
    check("rst_out_pc", bus.out_pc, 0);
`ifdef PIPE_SKID_PERF_EN
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_flush_cnt", flush_cnt, 0);
`endif
    tick();
    tick();
    rst = 1'b1;

    // Single entry: one-cycle latency, then popped
    drive(1'b1, 32'h0000_0013, 32'h100, 1'b1);
    #1;
    check("first_in_ready", bus.in_ready, 1);
    tick();
    check("lat_out_valid", bus.out_valid, 1);
    check("lat_out_instr", bus.out_instr, 32'h0000_0013);
    check("lat_out_pc", bus.out_pc, 32'h100);
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    tick();
    check("pop_out_valid", bus.out_valid, 0);
    check("pop_out_instr", bus.out_instr, NOP);

    // Stream 1..8 with back-pressure, then drain in order
    idx = 1;
    got_q.delete();
    for (int c = 0; c < 40 && got_q.size() < 8; c++) begin
      drive(idx <= 8, 32'(idx), 32'(idx * 4), (c == 0) || (c >= 6));
      #1;
      if (c == 4) begin
        check("two_in_ready", bus.in_ready, 0);
        check("two_out_valid", bus.out_valid, 1);
        check("two_out_instr", bus.out_instr, 32'h1);
      end
      if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_instr);
      if (bus.in_valid && bus.in_ready) idx++;
      @(posedge clk);
      #1;
    end
    check("stream_count", 64'(got_q.size()), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      check($sformatf("stream_order_%0d", i), got_q[i], 64'(i + 1));
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    check("stream_empty", bus.out_valid, 0);

    // Flush together with stall while in TWO
    drive(1'b1, 32'hAA, 32'hA00, 1'b0);
    tick();
    drive(1'b1, 32'hBB, 32'hB00, 1'b0);
    tick();
    check("pre_flush_in_ready", bus.in_ready, 0);
    stall = 1'b1;
    flush = 1'b1;
    drive(1'b1, 32'hCC, 32'hC00, 1'b1);
    tick();
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    #1;
    check("flush_out_valid", bus.out_valid, 0);
    check("flush_out_instr", bus.out_instr, NOP);
    check("flush_in_ready", bus.in_ready, 1);
`ifdef PIPE_SKID_PERF_EN
    check("flush_cnt_1", flush_cnt, 1);
    check("flush_stall_cnt_0", stall_cnt, 0);
`endif

    // Five-cycle stall in ONE with out_ready high
    drive(1'b1, 32'h44, 32'h440, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("stall_valid_%0d", i), bus.out_valid, 1);
      check($sformatf("stall_instr_%0d", i), bus.out_instr, 32'h44);
      check($sformatf("stall_pc_%0d", i), bus.out_pc, 32'h440);
    end
`ifdef PIPE_SKID_PERF_EN
    check("stall_cnt_5", stall_cnt, 5);
`endif
    stall = 1'b0;
    tick();
    check("unstall_pop", bus.out_valid, 0);

    // Asynchronous reset between edges
    drive(1'b1, 32'h55, 32'h550, 1'b0);
    tick();
    check("pre_rst_valid", bus.out_valid, 1);
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_valid", bus.out_valid, 0);
    check("async_rst_instr", bus.out_instr, NOP);
    check("async_rst_pc", bus.out_pc, 0);
    check("async_rst_in_ready", bus.in_ready, 0);
`ifdef PIPE_SKID_PERF_EN
    check("async_rst_stall_cnt", stall_cnt, 0);
    check("async_rst_flush_cnt", flush_cnt, 0);
`endif
    tick();
    rst = 1'b1;

    // Random stream against a FIFO model
    model_q.delete();
    m_stall_cnt = 0;
    m_flush_cnt = 0;
    for (int c = 0; c < 300; c++) begin
      drive(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 15) == 0);
      #1;
      m_ready = (model_q.size() < 2) && !stall;
      check("rnd_in_ready", bus.in_ready, m_ready);
      check("rnd_out_valid", bus.out_valid, model_q.size() > 0);
      if (model_q.size() > 0) begin
        check("rnd_out_instr", bus.out_instr, model_q[0][63:32]);
        check("rnd_out_pc", bus.out_pc, model_q[0][31:0]);
      end else begin
        check("rnd_out_nop", bus.out_instr, NOP);
      end
`ifdef PIPE_SKID_PERF_EN
      check("rnd_stall_cnt", stall_cnt, 64'(m_stall_cnt));
      check("rnd_flush_cnt", flush_cnt, 64'(m_flush_cnt));
`endif
      if (flush) begin
        if (model_q.size() > 0) m_flush_cnt++;
        model_q.delete();
      end else if (stall) begin
        m_stall_cnt++;
      end else begin
        if (model_q.size() > 0 && bus.out_ready) void'(model_q.pop_front());
        if (bus.in_valid && m_ready) model_q.push_back({bus.in_instr, bus.in_pc});
      end
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The block SHALL have these parameters:
- DATA_W, 32, instruction payload width.
- PC_W, 32, program-counter sideband width.
- NOP_WORD, 32'h0000_0000, value driven on out_instr when the stage holds no valid entry.
- CNT_W, 16, performance-counter width.

REQ-002 The block SHALL have these ports (direction, width, meaning):
- clk, in, 1: rising-edge clock.
- rst, in, 1: asynchronous, active-low reset.
- in_valid, in, 1: upstream entry valid.
- in_ready, out, 1: stage can accept an entry.
- in_instr, in, DATA_W: upstream instruction.
- in_pc, in, PC_W: upstream PC.
- stall, in, 1: hazard hold.
- flush, in, 1: squash all held entries.
- out_valid, out, 1: downstream entry valid.
- out_ready, in, 1: downstream can take an entry.
- out_instr, out, DATA_W: held instruction.
- out_pc, out, PC_W: held PC.
- stall_cnt, out, CNT_W: stall cycles; present only under the configuration macro.
- flush_cnt, out, CNT_W: flushes that discarded at least one valid entry; present only under the configuration macro.

Function
REQ-003 Storage SHALL be two slots, MAIN (drives the outputs) and SKID, each holding a valid flag, instr and pc.
REQ-004 Occupancy states SHALL be EMPTY, ONE (MAIN valid) and TWO (MAIN and SKID valid); SKID valid with MAIN invalid SHALL never occur.
REQ-005 in_ready SHALL equal !SKID.valid && !stall, and SHALL be a function of registered state and stall only, never of out_ready.
REQ-006 A push SHALL occur when in_valid && in_ready; a pop SHALL occur when out_valid && out_ready && !stall.
REQ-007 Latency SHALL be exactly 1 cycle: an entry pushed into EMPTY appears on the outputs at the next edge.
REQ-008 Throughput SHALL be one entry per cycle in state ONE when push and pop occur together.
REQ-009 Transitions:
- EMPTY+push -> ONE.
- ONE+push, no pop -> TWO (entry goes to SKID).
- ONE+pop, no push -> EMPTY.
- ONE+push+pop -> ONE (MAIN is overwritten).
- TWO+pop -> ONE (SKID moves to MAIN); push is impossible in TWO.
REQ-010 When stall=1 and flush=0, state and all slot contents SHALL be held unchanged.
REQ-011 When flush=1, both valid flags SHALL clear at the next edge and MAIN.instr SHALL load NOP_WORD, regardless of stall, in_valid or out_ready; the entry presented that cycle SHALL be discarded.
REQ-012 out_valid SHALL equal MAIN.valid; out_instr SHALL read NOP_WORD whenever out_valid=0.
REQ-013 out_instr, out_pc and out_valid SHALL be driven directly from flops, with no combinational path from inputs.
REQ-014 Entries SHALL leave in arrival order; no entry SHALL be duplicated or dropped except by flush.

Reset
REQ-015 Asserting rst=0 SHALL immediately clear both valid flags, set MAIN.instr and SKID.instr to NOP_WORD, set both PCs to 0 and zero both counters, including mid-transfer.
REQ-016 During reset, in_ready SHALL read 0; after rst rises, the first push SHALL be accepted at the first edge with in_valid=1 and stall=0.

Configuration
REQ-017 With PIPE_SKID_PERF_EN defined:
- stall_cnt SHALL increment on each cycle with stall=1 && flush=0.
- flush_cnt SHALL increment on each flush cycle in which out_valid=1 or SKID.valid=1.
- Both counters SHALL saturate at all-ones.
REQ-018 Without PIPE_SKID_PERF_EN, the stall_cnt and flush_cnt ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-019 NOP_WORD default, ZERO_WORD and the occupancy-state encoding SHALL live in the shared package pipe_pkg.
REQ-020 Counters SHALL be one sub-module, pipe_perf_cnt, instantiated twice under the macro; the slot logic SHALL stay in pipe_skid_reg.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset, then push 0x0000_0013 with pc 0x100 and out_ready=1 -> next cycle out_valid=1, out_instr=0x0000_0013, out_pc=0x100.
- Stream 0x1..0x8 with out_ready=0 from cycle 2 -> state TWO, in_ready=0; on release, 0x1..0x8 drain in order with no loss.
- In state TWO, assert stall and flush together -> next cycle out_valid=0, out_instr=NOP_WORD, in_ready=1; flush_cnt increments by 1 under PIPE_SKID_PERF_EN.
- Stall for 5 cycles while in ONE with out_ready=1 -> outputs frozen, no pop; stall_cnt increases by 5.
- Drop rst to 0 mid-stream between clock edges -> out_valid=0 and out_instr=NOP_WORD immediately, without a clock edge.
- Build once with the macro and once without, run the same random stream -> identical output traces.
